// File: rtl/frodo_decode_param_pkg.sv
// Shared FrodoKEM decode parameters: level constants, level/state encodings, small helpers.
// Purely declarative; no logic of its own.
`ifndef FRODO_CLOG2
`define FRODO_CLOG2(x) (((x) <= 1) ? 1 : $clog2(x))
`endif

package frodo_decode_param_pkg;

    localparam int L1_B      = 2;
    localparam int L1_D      = 15;
    localparam int L1_LEN_MU = 128;
    localparam int L3_B      = 3;
    localparam int L3_D      = 16;
    localparam int L3_LEN_MU = 192;
    localparam int L5_B      = 4;
    localparam int L5_D      = 16;
    localparam int L5_LEN_MU = 256;
    localparam int L5_MBAR   = 8;
    localparam int L5_NBAR   = 8;

    typedef enum logic [1:0] {LVL1, LVL3, LVL5} sec_lvl_t;

    typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_DRAIN, ST_DONE} state_t;

    function automatic int clog2_min1(input int n);
        return `FRODO_CLOG2(n);
    endfunction

    function automatic logic lvl_legal(input logic [2:0] s);
        return (s == 3'd1) || (s == 3'd3) || (s == 3'd5);
    endfunction

    function automatic sec_lvl_t lvl_from(input logic [2:0] s);
        case (s)
            3'd1:    return LVL1;
            3'd3:    return LVL3;
            default: return LVL5;
        endcase
    endfunction

    function automatic int lvl_bits(input sec_lvl_t l);
        case (l)
            LVL1:    return L1_B;
            LVL3:    return L3_B;
            default: return L5_B;
        endcase
    endfunction

endpackage

// File: rtl/frodo_dec_round.sv
// Single-coefficient rounder: low D bits, add half-step, keep top B bits (carry dropped).
// Combinational, zero latency; no flow control.
// Output bits above B are always zero so results can be OR-packed.
module frodo_dec_round
    import frodo_decode_param_pkg::*;
(
    input  logic [15:0] x,
    input  sec_lvl_t    lvl,
    output logic [3:0]  c
);

    logic [15:0] sum;

    always_comb begin
        sum = '0;
        c   = '0;
        case (lvl)
            LVL1: begin
                sum = 16'(x[L1_D-1:0]) + 16'(1 << (L1_D - L1_B - 1));
                c   = 4'(sum[L1_D-1 -: L1_B]);
            end
            LVL3: begin
                sum = x + 16'(1 << (L3_D - L3_B - 1));
                c   = 4'(sum[L3_D-1 -: L3_B]);
            end
            default: begin
                sum = x + 16'(1 << (L5_D - L5_B - 1));
                c   = 4'(sum[L5_D-1 -: L5_B]);
            end
        endcase
    end

endmodule

// File: rtl/frodo_decode_param.sv
// Key-decode engine: streams the 8x8 matrix from memory, rounds T coefficients per word into key k.
// Latency: done in cycle W+MEM_LAT+1 after the accepted start; one read issued per cycle, no stalls.
// No backpressure: the memory must return data exactly MEM_LAT cycles after each read enable.
module frodo_decode_param
    import frodo_decode_param_pkg::*;
#(
    parameter  int T       = 4,
    parameter  int MEM_LAT = 1,
    localparam int W       = (L5_MBAR * L5_NBAR) / T,
    localparam int AW      = clog2_min1(W)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [2:0]        i_sec_level,
    output logic              o_k_mat_en,
    output logic [AW-1:0]     o_k_mat_addr,
    input  logic [16*T-1:0]   i_k_mat,
    output logic [255:0]      o_k,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err
);

    state_t          state, state_nxt;
    sec_lvl_t        lvl_q, lvl_nxt;
    logic            err_q, err_nxt;
    logic            en_nxt;
    logic [AW-1:0]   addr_nxt;
    logic            clr_k;

    logic [MEM_LAT-1:0] vld_d, vld_shift;
    logic [AW-1:0]      addr_d [MEM_LAT];

    logic [3:0]      coef [T];
    logic [255:0]    word_bits, k_wr;
    int              b_bits;

    for (genvar g = 0; g < T; g++) begin : g_round
        frodo_dec_round u_round (
            .x   (i_k_mat[16*g +: 16]),
            .lvl (lvl_q),
            .c   (coef[g])
        );
    end

    // Stages below the output stage; empty means the last outstanding word is returning now.
    assign vld_shift = vld_d << 1;

    always_comb begin
        state_nxt = state;
        lvl_nxt   = lvl_q;
        err_nxt   = err_q;
        en_nxt    = 1'b0;
        addr_nxt  = o_k_mat_addr;
        clr_k     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_start) begin
                    clr_k = 1'b1;
                    if (lvl_legal(i_sec_level)) begin
                        lvl_nxt   = lvl_from(i_sec_level);
                        err_nxt   = 1'b0;
                        en_nxt    = 1'b1;
                        addr_nxt  = '0;
                        state_nxt = ST_READ;
                    end else begin
                        err_nxt   = 1'b1;
                        state_nxt = ST_DONE;
                    end
                end
            end
            ST_READ: begin
                if (o_k_mat_addr == AW'(W - 1)) begin
                    state_nxt = ST_DRAIN;
                end else begin
                    en_nxt   = 1'b1;
                    addr_nxt = o_k_mat_addr + AW'(1);
                end
            end
            ST_DRAIN: begin
                if (vld_shift == '0) state_nxt = ST_DONE;
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Rounded bits of one word, placed at the word's key offset.
    always_comb begin
        b_bits    = lvl_bits(lvl_q);
        word_bits = '0;
        for (int j = 0; j < T; j++) begin
            word_bits = word_bits | (256'(coef[j]) << (j * b_bits));
        end
        k_wr = word_bits << (int'(addr_d[MEM_LAT-1]) * T * b_bits);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= ST_IDLE;
            lvl_q        <= LVL1;
            err_q        <= 1'b0;
            o_k_mat_en   <= 1'b0;
            o_k_mat_addr <= '0;
            vld_d        <= '0;
            for (int s = 0; s < MEM_LAT; s++) addr_d[s] <= '0;
            o_k          <= '0;
        end else begin
            state        <= state_nxt;
            lvl_q        <= lvl_nxt;
            err_q        <= err_nxt;
            o_k_mat_en   <= en_nxt;
            o_k_mat_addr <= addr_nxt;
            vld_d        <= vld_shift | MEM_LAT'(o_k_mat_en);
            addr_d[0]    <= o_k_mat_addr;
            for (int s = 1; s < MEM_LAT; s++) addr_d[s] <= addr_d[s-1];
            if (clr_k) begin
                o_k <= '0;
            end else if (vld_d[MEM_LAT-1]) begin
                o_k <= o_k | k_wr;
            end
        end
    end

    assign o_busy = (state != ST_IDLE);
    assign o_done = (state == ST_DONE);
    assign o_err  = (state == ST_DONE) && err_q;

endmodule

// File: tb/tb_frodo_decode_param.sv
// Bench for frodo_decode_param: five T/MEM_LAT variants run in lockstep on a shared matrix,
// each compared every cycle against a plain-arithmetic key model.
module tb_frodo_decode_param;

    localparam int NCFG = 5;

    function automatic int cfg_t(input int g);
        case (g)
            0: return 4;
            1: return 1;
            2: return 1;
            3: return 8;
            default: return 8;
        endcase
    endfunction

    function automatic int cfg_l(input int g);
        case (g)
            0: return 1;
            1: return 1;
            2: return 4;
            3: return 1;
            default: return 4;
        endcase
    endfunction

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [2:0]   sec;
    logic [15:0]  mat [64];
    logic         busy0;

    int           n_chk = 0;
    int           n_err = 0;
    int           cyc = 0;
    bit           exp_err;
    int           exp_ndone;
    logic [255:0] exp_key;
    event         endrun;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    // Reference: round every coefficient with integer arithmetic and lay the bits out LSB-first.
    function automatic logic [255:0] model_key(input int lvl);
        int d, b, x, c;
        logic [255:0] r;
        r = '0;
        case (lvl)
            1: begin d = 15; b = 2; end
            3: begin d = 16; b = 3; end
            default: begin d = 16; b = 4; end
        endcase
        for (int i = 0; i < 64; i++) begin
            x = int'(mat[i]) % (1 << d);
            c = ((x + (1 << (d - b - 1))) >> (d - b)) % (1 << b);
            for (int bb = 0; bb < b; bb++) r[i*b + bb] = 1'((c >> bb) & 1);
        end
        return r;
    endfunction

    // Cycle 1 is the cycle after the edge that accepts a start.
    always @(posedge clk) cyc <= (start && !busy0) ? 1 : cyc + 1;

    for (genvar g = 0; g < NCFG; g++) begin : cfg
        localparam int TT  = cfg_t(g);
        localparam int LL  = cfg_l(g);
        localparam int WW  = 64 / TT;
        localparam int AWL = $clog2(WW);

        logic               en;
        logic [AWL-1:0]     addr;
        logic [16*TT-1:0]   rdat;
        logic [255:0]       k;
        logic               busy, done, err;
        logic [16*TT-1:0]   pipe [LL];
        logic [16*TT-1:0]   w;
        int                 n_done = 0;
        int                 done_cyc = 0;

        frodo_decode_param #(.T(TT), .MEM_LAT(LL)) dut (
            .i_clk        (clk),
            .i_rst_n      (rst_n),
            .i_start      (start),
            .i_sec_level  (sec),
            .o_k_mat_en   (en),
            .o_k_mat_addr (addr),
            .i_k_mat      (rdat),
            .o_k          (k),
            .o_busy       (busy),
            .o_done       (done),
            .o_err        (err)
        );

        // Memory with fixed latency LL; junk is returned in cycles with no read.
        assign rdat = pipe[LL-1];
        always @(posedge clk) begin
            for (int j = 0; j < TT; j++) w[16*j +: 16] = en ? mat[int'(addr)*TT + j] : 16'($urandom);
            for (int s = LL - 1; s > 0; s--) pipe[s] <= pipe[s-1];
            pipe[0] <= w;
        end

        always @(negedge clk) begin
            if (en) chk_int($sformatf("cfg%0d_read_cycle", g), cyc, exp_err ? -1 : int'(addr) + 1);
            if (done) begin
                n_done++;
                done_cyc = cyc;
                chk_int($sformatf("cfg%0d_done_cycle", g), cyc, exp_err ? 1 : WW + LL + 1);
                chk_int($sformatf("cfg%0d_err", g), int'(err), int'(exp_err));
                if (!exp_err) chk($sformatf("cfg%0d_key", g), k, exp_key);
            end
        end

        always @(endrun) begin
            chk_int($sformatf("cfg%0d_done_count", g), n_done, exp_ndone);
            n_done = 0;
        end

        always @(negedge rst_n) begin
            #1;
            chk_int($sformatf("cfg%0d_reset_ctl", g), int'({en, busy, done, err, addr}), 0);
            chk($sformatf("cfg%0d_reset_key", g), k, '0);
        end
    end

    assign busy0 = cfg[0].busy;

    task automatic fill(input logic [15:0] v);
        for (int i = 0; i < 64; i++) mat[i] = v;
    endtask

    task automatic fill_rand();
        logic [15:0] edges [4];
        edges[0] = 16'hF800; edges[1] = 16'hF7FF; edges[2] = 16'h0FFF; edges[3] = 16'h1000;
        for (int i = 0; i < 64; i++)
            mat[i] = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 3)] : 16'($urandom);
    endtask

    task automatic run(input logic [2:0] lvl, input bit inj, input int rst_at);
        exp_err   = !(lvl == 3'd1 || lvl == 3'd3 || lvl == 3'd5);
        exp_key   = model_key(int'(lvl));
        exp_ndone = 1;
        @(negedge clk);
        sec   = lvl;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        sec   = 3'($urandom);
        chk_int("busy_cycle1", int'(busy0), 1);
        for (int t = 0; t < 80; t++) begin
            @(negedge clk);
            start = inj && (cyc == 5);
            if (rst_at > 0 && cyc == rst_at && rst_n) begin
                rst_n     = 1'b0;
                exp_ndone = 0;
            end else if (rst_at > 0 && cyc == rst_at + 3) begin
                rst_n = 1'b1;
            end
        end
        #2;
        ->endrun;
        #1;
        chk_int("busy_after_run", int'(busy0), 0);
        if (!exp_err && rst_at == 0) chk("key_held", cfg[0].k, exp_key);
    endtask

    initial begin
        logic [255:0] lit;
        logic [2:0]   lv;
        rst_n = 1'b1;
        start = 1'b0;
        sec   = 3'd0;
        fill(16'h0);
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        fill(16'h2000);
        lit = {128'h0, {16{8'h55}}};
        chk("model_l1_pin", model_key(1), lit);
        run(3'd1, 1'b0, 0);
        chk("l1_key_literal", cfg[0].k, lit);
        chk_int("l1_done_cycle18", cfg[0].done_cyc, 18);

        fill(16'h8000);
        lit = '0;
        for (int n = 0; n < 24; n++) lit[8*n +: 8] = (n % 3 == 0) ? 8'h24 : (n % 3 == 1) ? 8'h49 : 8'h92;
        chk("model_l3_pin", model_key(3), lit);
        run(3'd3, 1'b0, 0);
        chk("l3_key_literal", cfg[0].k, lit);

        fill(16'hF800);
        chk("model_l5_wrap_pin", model_key(5), '0);
        run(3'd5, 1'b0, 0);
        chk("l5_wrap_literal", cfg[0].k, '0);

        fill(16'hF7FF);
        chk("model_l5_max_pin", model_key(5), {256{1'b1}});
        run(3'd5, 1'b0, 0);
        chk("l5_max_literal", cfg[0].k, {256{1'b1}});

        fill(16'h0);
        mat[0] = 16'h1000;
        chk("model_l5_one_pin", model_key(5), 256'h1);
        run(3'd5, 1'b0, 0);
        chk("l5_one_literal", cfg[0].k, 256'h1);

        for (int r = 0; r < 6; r++) begin
            fill_rand();
            lv = (r % 3 == 0) ? 3'd1 : (r % 3 == 1) ? 3'd3 : 3'd5;
            run(lv, r == 1, 0);
        end

        fill_rand();
        run(3'd2, 1'b0, 0);
        chk_int("illegal_done_cycle1", cfg[0].done_cyc, 1);
        run(3'd7, 1'b0, 0);

        fill_rand();
        run(3'd5, 1'b0, 9);
        fill_rand();
        run(3'd5, 1'b0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
